// File: rtl/status_mux_arbiter.sv
// status_mux_arbiter: round-robin arbiter and sequencer for the shared status/shadow
// register. It grants one requester at a time and captures its data slice. The grant
// is held for HOLD cycles after capture, then the block pulses done (or abort) and
// rotates priority.
// Optional feature: define STATUS_ARB_PRIO_EN to make requester 0 high-priority.
// In IDLE it always wins, and a grant to requester 0 leaves the rotation pointer untouched.
module status_mux_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 14,
  parameter int unsigned HOLD = 2,
  parameter int unsigned IW   = 2
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      gnt,
  output logic [DW-1:0]        shared_q,
  output logic [IW-1:0]        q_src,
  output logic                 busy,
  output logic                 done,
  output logic                 abort
);

  // Hold counter only ever holds HOLD-1 down to 0.
  localparam int unsigned CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e          state_q;
  logic [NREQ-1:0] gnt_q;
  logic [DW-1:0]   shared_data_q;
  logic [IW-1:0]   src_q;
  logic            busy_q;
  logic            done_q;
  logic            abort_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   win_q;
  logic [CW-1:0]   cnt_q;

  logic [IW-1:0]   win_c;
  logic [IW-1:0]   ptr_d;

  assign gnt      = gnt_q;
  assign shared_q = shared_data_q;
  assign q_src    = src_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign abort    = abort_q;

  // Winner select: first requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    win_c = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      if (req[(int'(ptr_q) + k) % int'(NREQ)]) begin
        win_c = IW'((int'(ptr_q) + k) % int'(NREQ));
      end
    end
`ifdef STATUS_ARB_PRIO_EN
    if (req[0]) begin
      win_c = '0;
    end
`endif
  end

  // Pointer after a finished or aborted transaction: one past the winner.
  always_comb begin
    ptr_d = (int'(win_q) == int'(NREQ) - 1) ? '0 : win_q + IW'(1);
`ifdef STATUS_ARB_PRIO_EN
    if (win_q == '0) begin
      ptr_d = ptr_q;
    end
`endif
  end

  // Sequencer: IDLE -> GRANT (capture) -> HOLD (count down) -> IDLE, with abort on req drop.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      gnt_q         <= '0;
      shared_data_q <= '0;
      src_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      abort_q       <= 1'b0;
      ptr_q         <= '0;
      win_q         <= '0;
      cnt_q         <= '0;
    end else begin
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            gnt_q   <= NREQ'(1) << win_c;
            win_q   <= win_c;
            busy_q  <= 1'b1;
            state_q <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (!req[win_q]) begin
            gnt_q   <= '0;
            abort_q <= 1'b1;
            ptr_q   <= ptr_d;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            shared_data_q <= req_data[int'(win_q)*int'(DW) +: DW];
            src_q         <= win_q;
            cnt_q         <= CW'(HOLD - 1);
            state_q       <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // A dropped request wins over completion on the final hold edge.
          if (!req[win_q]) begin
            gnt_q   <= '0;
            abort_q <= 1'b1;
            ptr_q   <= ptr_d;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            gnt_q   <= '0;
            done_q  <= 1'b1;
            ptr_q   <= ptr_d;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_status_mux_arbiter.sv
// Testbench for status_mux_arbiter.
// The driver issues transactions and pushes the expected outcome into a scoreboard.
// The monitor pops an entry on every done/abort pulse and checks it.
module tb_status_mux_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 14;
  localparam int unsigned HOLD = 2;
  localparam int unsigned IW   = 2;

  logic                sysclk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req;
  logic [NREQ*DW-1:0]  req_data;
  logic [NREQ-1:0]     gnt;
  logic [DW-1:0]       shared_q;
  logic [IW-1:0]       q_src;
  logic                busy;
  logic                done;
  logic                abort;

  status_mux_arbiter #(.NREQ(NREQ), .DW(DW), .HOLD(HOLD), .IW(IW)) dut (
    .sysclk   (sysclk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .shared_q (shared_q),
    .q_src    (q_src),
    .busy     (busy),
    .done     (done),
    .abort    (abort)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    int           win;
    bit           is_abort;
    logic [DW-1:0] shared;
    int           qsrc;
    int           gcyc;
    int           at;
  } exp_t;

  exp_t          sb[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            mon_cyc = 0;

  // Reference state at transaction level.
  int            ptr_m = 0;
  logic [DW-1:0] shared_m = '0;
  int            qsrc_m = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Winner chosen by the arbitration rule from the request mask seen in IDLE.
  function automatic int model_win(input logic [NREQ-1:0] m);
`ifdef STATUS_ARB_PRIO_EN
    if (m[0]) return 0;
`endif
    for (int k = 0; k < int'(NREQ); k++) begin
      if (m[(ptr_m + k) % int'(NREQ)]) return (ptr_m + k) % int'(NREQ);
    end
    return -1;
  endfunction

  // One transaction, entered and left just after a falling edge.
  // k < 0 completes normally; k in 0..HOLD drops the winner's request before edge E(k+1).
  task automatic txn(input logic [NREQ-1:0] mask, input int k, input bit idle_after,
                     input logic [DW-1:0] wdata, input bit jitter);
    int              w;
    int              last_edge;
    logic [NREQ-1:0] oh;
    exp_t            e;
    w  = model_win(mask);
    oh = NREQ'(1) << w;
    req = mask;
    for (int i = 0; i < int'(NREQ); i++) begin
      req_data[i*DW +: DW] = (i == w) ? wdata : DW'($urandom);
    end
    last_edge  = (k >= 0) ? k + 1 : int'(HOLD) + 1;
    e.win      = w;
    e.is_abort = (k >= 0);
    if (k != 0) begin
      shared_m = wdata;
      qsrc_m   = w;
    end
    e.shared = shared_m;
    e.qsrc   = qsrc_m;
    e.gcyc   = last_edge;
    e.at     = mon_cyc + 1 + last_edge;
`ifdef STATUS_ARB_PRIO_EN
    if (w != 0)
`endif
      ptr_m = (w + 1) % int'(NREQ);
    sb.push_back(e);
    @(posedge sysclk);
    for (int j = 1; j <= last_edge; j++) begin
      @(negedge sysclk);
      if (jitter) begin
        req = (req & oh) | (NREQ'($urandom) & ~oh);
        for (int i = 0; i < int'(NREQ); i++) begin
          if (i != w) req_data[i*DW +: DW] = DW'($urandom);
        end
      end
      if (k >= 0 && j == k + 1) req[w] = 1'b0;
      @(posedge sysclk);
    end
    @(negedge sysclk);
    if (idle_after) begin
      req = '0;
      repeat ($urandom_range(0, 2)) @(negedge sysclk);
    end
  endtask

  // Monitor: samples 2 time units after each rising edge.
  // It counts grant cycles and checks every completion/abort pulse against the scoreboard.
  initial begin : monitor
    int              gcnt;
    logic [NREQ-1:0] last_g;
    exp_t            e;
    gcnt   = 0;
    last_g = '0;
    forever begin
      @(posedge sysclk);
      #2;
      mon_cyc++;
      if (!reset) begin
        gcnt   = 0;
        last_g = '0;
      end else begin
        chk("busy_vs_gnt", 32'(busy), 32'(|gnt));
        chk("done_abort_excl", 32'(done & abort), 32'(0));
        if (done || abort) begin
          chk("pulse_expected", 32'(sb.size() != 0), 32'(1));
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("abort_flag", 32'(abort), 32'(e.is_abort));
            chk("shared_q", 32'(shared_q), 32'(e.shared));
            chk("q_src", 32'(q_src), 32'(e.qsrc));
            chk("gnt_onehot", 32'(last_g), 32'(NREQ'(1) << e.win));
            chk("gnt_cycles", 32'(gcnt), 32'(e.gcyc));
            chk("pulse_cycle", 32'(mon_cyc), 32'(e.at));
            chk("gnt_released", 32'(gnt), 32'(0));
          end
          gcnt   = 0;
          last_g = '0;
        end else if (gnt != '0) begin
          gcnt++;
          last_g = gnt;
        end
      end
    end
  end

  // Stimulus: reset, directed cases, random traffic, mid-HOLD reset.
  initial begin : driver
    logic [NREQ-1:0] m;
    int              k;
    reset    = 1'b0;
    req      = '0;
    req_data = '0;
    repeat (2) @(negedge sysclk);
    chk("rst_gnt", 32'(gnt), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_shared", 32'(shared_q), 32'(0));
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge sysclk);
      chk("idle_gnt", 32'(gnt), 32'(0));
      chk("idle_done", 32'(done), 32'(0));
      chk("idle_shared", 32'(shared_q), 32'(0));
    end

    // Single requester 2 with a known word.
    txn(4'b0100, -1, 1'b1, 14'h1A5, 1'b0);
    // All requesting continuously: strict rotation with one bubble between grants.
    for (int i = 0; i < 5; i++) txn(4'b1111, -1, (i == 4), DW'($urandom), 1'b0);
    // Requester 1 drops in HOLD, then 1 and 2 both request.
    txn(4'b0010, 1, 1'b0, DW'($urandom), 1'b0);
    txn(4'b0110, -1, 1'b1, DW'($urandom), 1'b0);
    // Abort on the final hold edge and abort in GRANT.
    txn(4'b1000, int'(HOLD), 1'b1, DW'($urandom), 1'b0);
    txn(4'b0001, 0, 1'b1, DW'($urandom), 1'b0);

    for (int n = 0; n < 200; n++) begin
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, HOLD)) : -1;
      txn(m, k, 1'($urandom_range(0, 1)), DW'($urandom), 1'b1);
    end

    // Reset in the middle of HOLD: grant and register clear immediately, no pulse.
    req = 4'b0010;
    req_data = {NREQ*DW{1'b1}};
    @(posedge sysclk);
    @(negedge sysclk);
    @(posedge sysclk);
    @(negedge sysclk);
    reset = 1'b0;
    #1;
    chk("midrst_gnt", 32'(gnt), 32'(0));
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_shared", 32'(shared_q), 32'(0));
    chk("midrst_done", 32'(done | abort), 32'(0));
    @(negedge sysclk);
    req      = '0;
    reset    = 1'b1;
    ptr_m    = 0;
    shared_m = '0;
    qsrc_m   = 0;
    txn(4'b1010, -1, 1'b1, DW'($urandom), 1'b0);

    repeat (4) @(negedge sysclk);
    chk("sb_drained", 32'(sb.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
